huffman_unary_decoder: RTL and testbench

HUFFMAN_UNARY_DECODER -- requirements
Module: huffman_unary_decoder

---
 rtl/huffman_pkg.sv | 32 +++
 rtl/huffman_table.sv | 60 ++++++
 rtl/huffman_unary_decoder.sv | 136 +++++++++++++
 tb/tb_huffman_unary_decoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_pkg
//  Description : Shared defaults, truncation-mode constants and a ceiling
//                log2 helper for the unary/truncated-unary Huffman decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package huffman_pkg;

    // Default output symbol width and longest codeword length.
    localparam int SYM_W_DEFAULT   = 4;
    localparam int MAX_LEN_DEFAULT = 8;

    // Code modes selected by the TRUNC parameter.
    localparam int TRUNC_STRICT = 0;  // strict unary, overrun raises err
    localparam int TRUNC_UNARY  = 1;  // truncated unary, terminal all-zero word

    // Ceiling log2; clog2(8) = 3, clog2(2) = 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : huffman_pkg
`default_nettype wire

// File: rtl/huffman_table.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_table
//  Description : MAX_LEN x SYM_W symbol register file. One synchronous write
//                port, one asynchronous read port, identity contents after
//                reset (entry i holds i truncated to SYM_W).
//  Ports       : clk      - clock
//                rst      - synchronous active-low reset
//                we_i     - write strobe
//                waddr_i  - write index (values >= MAX_LEN are ignored)
//                wdata_i  - write data
//                raddr_i  - read index
//                rdata_o  - read data (combinational, pre-write value)
//  Revision    : 1.0  initial release
// ============================================================================
module huffman_table
    import huffman_pkg::*;
#(
    parameter int SYM_W   = SYM_W_DEFAULT,
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int CNT_W   = clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [CNT_W-1:0] waddr_i,
    input  logic [SYM_W-1:0] wdata_i,
    input  logic [CNT_W-1:0] raddr_i,
    output logic [SYM_W-1:0] rdata_o
);

    logic [SYM_W-1:0] mem_q [MAX_LEN];
    logic             w_addr_ok;

    // The range check only exists when the address field can encode
    // indices past the end of the table.
    generate
        if ((1 << CNT_W) > MAX_LEN) begin : g_addr_check
            assign w_addr_ok = (int'(waddr_i) < MAX_LEN);
        end else begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end
    endgenerate

    // Reading the register array directly means a lookup in the same cycle
    // as a write to that entry sees the value from before the edge.
    assign rdata_o = mem_q[raddr_i];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= SYM_W'(i);
            end
        end else if (we_i && w_addr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule : huffman_table
`default_nettype wire

// File: rtl/huffman_unary_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_unary_decoder
//  Description : Serial decoder for unary (k zeros then a one) and
//                truncated-unary codes. Counts the zero run, looks the
//                symbol up in a programmable table and presents it through a
//                single-entry valid/ready output register.
//  Ports       : clk         - clock
//                rst         - synchronous active-low reset
//                in_i        - serial code bit
//                in_valid_i  - in_i carries a bit
//                in_ready_o  - decoder accepts a bit this cycle
//                out_o       - decoded symbol
//                out_valid_o - out_o holds a symbol
//                out_ready_i - consumer takes out_o this cycle
//                tbl_we_i    - symbol-table write strobe
//                tbl_addr_i  - table index (= codeword zero count)
//                tbl_data_i  - table write data
//                err_o       - sticky overrun flag (strict mode only)
//  Revision    : 1.0  initial release
// ============================================================================
module huffman_unary_decoder
    import huffman_pkg::*;
#(
    parameter int SYM_W   = SYM_W_DEFAULT,
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int TRUNC   = TRUNC_UNARY,
    localparam int CNT_W  = clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [SYM_W-1:0] out_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic             tbl_we_i,
    input  logic [CNT_W-1:0] tbl_addr_i,
    input  logic [SYM_W-1:0] tbl_data_i,
    output logic             err_o
);

    // Count value at which the next zero is the truncated terminal zero.
    localparam logic [CNT_W-1:0] c_TERM_CNT = CNT_W'(MAX_LEN - 2);
    // Highest count value; a further zero is an overrun in strict mode.
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(MAX_LEN - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [SYM_W-1:0] out_q,   out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q,   err_d;
    // Set after an overrun: swallow zeros up to and including the next one.
    logic             drop_q,  drop_d;

    logic             w_accept;
    logic             w_trunc_term;
    logic [CNT_W-1:0] w_lookup;
    logic [SYM_W-1:0] w_sym;

    // Pass-through on drain; forced high while reset is asserted.
    assign in_ready_o = !rst || !out_valid_q || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    // The terminal zero of a truncated code addresses one entry past the
    // current count; a terminating one addresses the count itself.
    assign w_trunc_term = (TRUNC != TRUNC_STRICT) && !in_i && (count_q == c_TERM_CNT);
    assign w_lookup     = count_q + CNT_W'(!in_i);

    huffman_table #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we_i    (tbl_we_i),
        .waddr_i (tbl_addr_i),
        .wdata_i (tbl_data_i),
        .raddr_i (w_lookup),
        .rdata_o (w_sym)
    );

    always_comb begin
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        drop_d      = drop_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (drop_q) begin
                if (in_i) begin
                    drop_d  = 1'b0;
                    count_d = '0;
                end
            end else if (in_i || w_trunc_term) begin
                // A new symbol overrides the drain above: no bubble.
                out_d       = w_sym;
                out_valid_d = 1'b1;
                count_d     = '0;
            end else if ((TRUNC == TRUNC_STRICT) && (count_q == c_LAST_CNT)) begin
                err_d  = 1'b1;
                drop_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;

endmodule : huffman_unary_decoder
`default_nettype wire

// File: tb/tb_huffman_unary_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huffman_unary_decoder
//  Description : Directed self-checking bench. One truncated-unary instance
//                is checked through a scoreboard queue; one strict-unary
//                instance exercises the overrun flag.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_huffman_unary_decoder;

    localparam int SYM_W   = 4;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;

    // Truncated-unary instance
    logic             in_bit = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic             tbl_we = 1'b0;
    logic [CNT_W-1:0] tbl_addr = '0;
    logic [SYM_W-1:0] tbl_data = '0;
    logic             in_ready, out_valid, err;
    logic [SYM_W-1:0] out_sym;

    // Strict-unary instance
    logic             s_in = 1'b1, s_in_valid = 1'b0, s_out_ready = 1'b1;
    logic             s_tbl_we = 1'b0;
    logic [CNT_W-1:0] s_tbl_addr = '0;
    logic [SYM_W-1:0] s_tbl_data = '0;
    logic             s_in_ready, s_out_valid, s_err;
    logic [SYM_W-1:0] s_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [SYM_W-1:0] sb[$];
    logic [SYM_W-1:0] tbl_m [MAX_LEN];
    int               mdl_cnt = 0;
    logic             lat_chk = 1'b0;
    logic             hold_prev = 1'b0;
    logic [SYM_W-1:0] hold_val = '0;

    always #5 clk = ~clk;

    huffman_unary_decoder #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .TRUNC(1)) dut (
        .clk(clk), .rst(rst), .in_i(in_bit), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_o(out_sym), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data), .err_o(err)
    );

    huffman_unary_decoder #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .TRUNC(0)) dut_s (
        .clk(clk), .rst(rst), .in_i(s_in), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .out_o(s_out), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .tbl_we_i(s_tbl_we), .tbl_addr_i(s_tbl_addr), .tbl_data_i(s_tbl_data), .err_o(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAX_LEN; i++) tbl_m[i] = SYM_W'(i);
        mdl_cnt = 0;
        sb.delete();
        lat_chk = 1'b0;
    endtask

    // Output monitor: scoreboard pop, latency and hold-stability checks.
    always @(negedge clk) begin
        if (rst) begin
            if (lat_chk) begin
                chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
                lat_chk = 1'b0;
            end
            if (hold_prev) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {28'd0, out_sym}, {28'd0, hold_val});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {28'd0, out_sym}, 32'hFFFF_FFFF);
                end else begin
                    logic [SYM_W-1:0] e;
                    e = sb.pop_front();
                    chk("sb_symbol", {28'd0, out_sym}, {28'd0, e});
                end
            end
            hold_prev = out_valid && !out_ready;
            hold_val  = out_sym;
        end else begin
            hold_prev = 1'b0;
            lat_chk   = 1'b0;
        end
    end

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic send_bit(input logic b);
        int   n;
        logic term;
        n        = 0;
        in_bit   = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        term = b || (mdl_cnt == MAX_LEN - 2);
        if (term) begin
            sb.push_back(tbl_m[b ? mdl_cnt : mdl_cnt + 1]);
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
        @(posedge clk);
        #1;
        if (term) lat_chk = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_bit   = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tbl_write(input logic [CNT_W-1:0] a, input logic [SYM_W-1:0] d);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        tbl_m[a] = d;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_async", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {28'd0, out_sym}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_s_out_valid", {31'd0, s_out_valid}, 32'd0);
        chk("rst_s_err", {31'd0, s_err}, 32'd0);
        repeat (cycles - 1) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic s_bit(input logic b);
        s_in = b;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // Basic decode: 1 | 01 | 001 -> 0, 1, 2
        out_ready = 1'b1;
        send_bit(1); send_bit(0); send_bit(1);
        send_bit(0); send_bit(0); send_bit(1);
        idle(3);
        chk("sb_empty_basic", sb.size(), 32'd0);

        // Truncated terminal codeword: seven zeros -> 7
        for (int i = 0; i < MAX_LEN - 1; i++) send_bit(0);
        idle(3);
        chk("sb_empty_trunc", sb.size(), 32'd0);

        // Back-to-back ones: one symbol per cycle
        send_bit(1); send_bit(1); send_bit(1); send_bit(1);
        idle(3);
        chk("sb_empty_stream", sb.size(), 32'd0);

        // Backpressure: held symbol, stalled input, no loss or duplicate
        out_ready = 1'b0;
        send_bit(1);
        in_bit = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_bit(1); send_bit(1);
        idle(3);
        chk("sb_empty_backpressure", sb.size(), 32'd0);

        // Table programming and same-cycle write/lookup
        tbl_write(3'd2, 4'hA);
        send_bit(0); send_bit(0); send_bit(1);
        tbl_we = 1'b1; tbl_addr = 3'd0; tbl_data = 4'h5;
        send_bit(1);
        tbl_we = 1'b0;
        tbl_m[0] = 4'h5;
        send_bit(1);
        idle(3);
        chk("sb_empty_table", sb.size(), 32'd0);

        // Reset while a symbol is held: in_ready high, symbol discarded
        out_ready = 1'b0;
        send_bit(1);
        in_valid = 1'b0;
        chk("held_before_reset", {31'd0, out_valid}, 32'd1);
        chk("held_in_ready", {31'd0, in_ready}, 32'd0);
        do_reset(2);
        out_ready = 1'b1;

        // Partial code discarded by reset; reset overrides table write
        send_bit(0); send_bit(0);
        in_valid = 1'b0;
        tbl_we = 1'b1; tbl_addr = 3'd1; tbl_data = 4'hF;
        do_reset(2);
        tbl_we = 1'b0;
        send_bit(1);
        send_bit(0); send_bit(1);
        idle(3);
        chk("sb_empty_reset", sb.size(), 32'd0);

        // Strict mode: 0,1 -> 1, then overrun on the eighth zero
        s_bit(0); s_bit(1);
        chk("s_valid_01", {31'd0, s_out_valid}, 32'd1);
        chk("s_out_01", {28'd0, s_out}, 32'd1);
        for (int i = 0; i < MAX_LEN; i++) begin
            s_bit(0);
            chk("s_zero_no_valid", {31'd0, s_out_valid}, 32'd0);
            chk("s_err_progress", {31'd0, s_err}, (i == MAX_LEN - 1) ? 32'd1 : 32'd0);
        end
        s_bit(1);
        chk("s_overrun_one_no_valid", {31'd0, s_out_valid}, 32'd0);
        chk("s_err_sticky1", {31'd0, s_err}, 32'd1);
        s_bit(1);
        chk("s_after_valid", {31'd0, s_out_valid}, 32'd1);
        chk("s_after_out", {28'd0, s_out}, 32'd0);
        chk("s_err_sticky2", {31'd0, s_err}, 32'd1);
        s_bit(0);
        chk("s_err_sticky3", {31'd0, s_err}, 32'd1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_huffman_unary_decoder
`default_nettype wire
